// File: rtl/modmul_pkg.sv
// Shared types and constants for the modular-multiplier arbiter.
// The field prime is 2^255 - 19 and elements are 255 bits wide.
package modmul_pkg;

  localparam int FE_W = 255;
  localparam logic [FE_W-1:0] P = {FE_W{1'b1}} - FE_W'(18);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/modmul_arbiter_rr.sv
// Combinational round-robin picker.
// Grants the first asserted request at or after ptr, wrapping around modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  function automatic int wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s;
  endfunction

  // Scan from the farthest offset down to ptr so the closest match is written last and wins.
  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = |req;
    j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'(wrap_idx(ptr, k));
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/modmul_arbiter.sv
// Shares one multi-cycle multiply-mod-p unit among NREQ requesters.
// Only one transaction is in flight at a time. A watchdog ends a transaction whose multiplier never completes.
module modmul_arbiter
  import modmul_pkg::*;
#(
  parameter int N       = FE_W,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [N-1:0]      rsp_prod,
  output logic              rsp_err,
  output logic              mul_en,
  output logic [N-1:0]      mul_x,
  output logic [N-1:0]      mul_y,
  input  logic [N-1:0]      mul_prod,
  input  logic              mul_dr
);

  localparam int IW   = $clog2(NREQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

  arb_state_t      state, state_d;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] grant_q;
  logic [N-1:0]    x_q, y_q, prod_q;
  logic            err_q;
  logic [WD_W-1:0] wdog;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [N-1:0]    sel_x, sel_y;
  logic            rsp_hs;
  logic            wd_expire;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_x = req_x[i*N +: N];
        sel_y = req_y[i*N +: N];
      end
    end
  end

  // Only the granted requester's rsp_ready can complete the response.
  assign rsp_hs    = |(rsp_ready & grant_q);
  assign wd_expire = (wdog == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    req_ready = '0;
    rsp_valid = '0;
    mul_en    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mul_en  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_dr || wd_expire) state_d = RESP;
      end
      RESP: begin
        rsp_valid = grant_q;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A data-ready pulse takes priority over a watchdog expiry in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      gidx    <= '0;
      grant_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      wdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            gidx    <= arb_idx;
            x_q     <= sel_x;
            y_q     <= sel_y;
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          wdog <= wdog + 1'b1;
          if (mul_dr) begin
            prod_q <= mul_prod;
            err_q  <= 1'b0;
          end else if (wd_expire) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            grant_q <= '0;
            ptr     <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_x    = x_q;
  assign mul_y    = y_q;
  assign rsp_prod = prod_q;
  assign rsp_err  = err_q;

endmodule
